// File: rtl/updown_mod_counter.sv
// Modulo up/down counter field for the timer datapath: run-time trimmable upper bound,
// parallel load, cascade carry/borrow, registered BCD image and optional button auto-repeat.
module updown_mod_counter #(
    parameter int WIDTH        = 8,
    parameter int MIN_VAL      = 0,
    parameter int MAX_VAL      = 59,
    parameter int MODE         = 1,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic             up,
    input  logic             down,
    input  logic             cin,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] lim,
    output logic [WIDTH-1:0] out,
    output logic [7:0]       bcd,
    output logic             carry,
    output logic             borrow
);
    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [7:0]       BCD_MIN = 8'(((MIN_VAL / 10) * 16) + (MIN_VAL % 10));

    logic [WIDTH-1:0] out_reg, out_next;
    logic [7:0]       bcd_reg, bcd_next;
    logic             carry_reg, carry_next;
    logic             borrow_reg, borrow_next;
    logic [WIDTH-1:0] emax;
    logic             dir_up, dir_dn;
    logic             step, step_up;
    logic [7:0]       bin;
    logic [8:0]       ge_ten;
    logic [3:0]       tens;
    logic [3:0]       ones;

    // Both buttons pressed cancel out and count as no direction.
    assign dir_up = up & ~down;
    assign dir_dn = down & ~up;

    always_comb begin
        emax = (lim < MAX_W) ? lim : MAX_W;
        if (emax < MIN_W) begin
            emax = MIN_W;
        end
    end

    generate
        if (MODE == 0) begin : g_level
            assign step    = EN & (dir_up | dir_dn);
            assign step_up = dir_up;
        end else begin : g_edge
            localparam int TICK_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
            localparam int CW       = $clog2(TICK_MAX + 1);
            localparam logic [CW-1:0] HOLD_C = CW'(HOLD_TICKS);
            localparam logic [CW-1:0] REP_C  = CW'(REPEAT_TICKS);

            typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

            state_t        state_reg;
            logic          dir_reg;
            logic [CW-1:0] cnt_reg;
            logic          same_dir;

            // dir_reg remembers the latched direction: 1 = up, 0 = down.
            assign same_dir = (dir_up & dir_reg) | (dir_dn & ~dir_reg);

            // The step decision must act on the same edge as the FSM update,
            // otherwise the first press would reach out one clock late.
            always_comb begin
                step    = 1'b0;
                step_up = dir_up;
                if (EN) begin
                    case (state_reg)
                        IDLE:    step = dir_up | dir_dn;
                        HOLD:    step = same_dir && (cnt_reg == HOLD_C);
                        REPEAT:  step = same_dir && (cnt_reg == REP_C);
                        default: step = 1'b0;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= IDLE;
                    dir_reg   <= 1'b0;
                    cnt_reg   <= '0;
                end else if (EN && !load) begin
                    case (state_reg)
                        IDLE: begin
                            if (dir_up | dir_dn) begin
                                dir_reg   <= dir_up;
                                cnt_reg   <= CW'(1);
                                state_reg <= HOLD;
                            end
                        end
                        HOLD: begin
                            if (!same_dir) begin
                                cnt_reg   <= '0;
                                state_reg <= IDLE;
                            end else if (cnt_reg == HOLD_C) begin
                                cnt_reg   <= CW'(1);
                                state_reg <= REPEAT;
                            end else begin
                                cnt_reg <= cnt_reg + CW'(1);
                            end
                        end
                        REPEAT: begin
                            if (!same_dir) begin
                                cnt_reg   <= '0;
                                state_reg <= IDLE;
                            end else if (cnt_reg == REP_C) begin
                                cnt_reg <= CW'(1);
                            end else begin
                                cnt_reg <= cnt_reg + CW'(1);
                            end
                        end
                        default: begin
                            cnt_reg   <= '0;
                            state_reg <= IDLE;
                        end
                    endcase
                end
            end
        end
    endgenerate

    // Range checks precede the +/-1, so the arithmetic never leaves [MIN_VAL, emax].
    always_comb begin
        out_next    = out_reg;
        carry_next  = 1'b0;
        borrow_next = 1'b0;
        if (load) begin
            if (din < MIN_W) begin
                out_next = MIN_W;
            end else if (din > emax) begin
                out_next = emax;
            end else begin
                out_next = din;
            end
        end else if (out_reg > emax) begin
            out_next = emax;
        end else if (cin || (step && step_up)) begin
            if (out_reg == emax) begin
                out_next   = MIN_W;
                carry_next = 1'b1;
            end else begin
                out_next = out_reg + WIDTH'(1);
            end
        end else if (step) begin
            if (out_reg == MIN_W) begin
                out_next    = emax;
                borrow_next = 1'b1;
            end else begin
                out_next = out_reg - WIDTH'(1);
            end
        end
    end

    // Count values never exceed 99, so an 8-bit image is enough for the BCD split.
    assign bin = 8'(out_next);

    genvar gi;
    for (gi = 0; gi < 9; gi++) begin : g_ten
        assign ge_ten[gi] = (bin >= 8'(10 * (gi + 1)));
    end

    always_comb begin
        tens = 4'd0;
        for (int k = 0; k < 9; k++) begin
            tens = tens + {3'b000, ge_ten[k]};
        end
        ones     = 4'(bin - (8'(tens) * 8'd10));
        bcd_next = {tens, ones};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg    <= MIN_W;
            bcd_reg    <= BCD_MIN;
            carry_reg  <= 1'b0;
            borrow_reg <= 1'b0;
        end else begin
            out_reg    <= out_next;
            bcd_reg    <= bcd_next;
            carry_reg  <= carry_next;
            borrow_reg <= borrow_next;
        end
    end

    assign out    = out_reg;
    assign bcd    = bcd_reg;
    assign carry  = carry_reg;
    assign borrow = borrow_reg;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: four instances (level, cascaded level, auto-repeat, offset range)
// checked every cycle by a scoreboard fed from a tick-count reference model.
module tb_updown_mod_counter;
    localparam int N = 4;
    localparam int P_MIN  [N] = '{0, 0, 0, 1};
    localparam int P_MAX  [N] = '{59, 59, 59, 31};
    localparam int P_MODE [N] = '{0, 0, 1, 1};
    localparam int P_HOLD [N] = '{4, 4, 4, 3};
    localparam int P_REP  [N] = '{2, 2, 2, 2};

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]      en_v, up_v, down_v, cin_v, load_v;
    logic [N-1:0][7:0] din_v, lim_v;
    logic [N-1:0][7:0] out_w, bcd_w;
    logic [N-1:0]      carry_w, borrow_w, cin_eff;

    // Instance 1 is the upper stage of a cascade driven by instance 0.
    assign cin_eff = {cin_v[3], cin_v[2], carry_w[0], cin_v[0]};

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        updown_mod_counter #(
            .WIDTH(8), .MIN_VAL(P_MIN[gi]), .MAX_VAL(P_MAX[gi]), .MODE(P_MODE[gi]),
            .HOLD_TICKS(P_HOLD[gi]), .REPEAT_TICKS(P_REP[gi])
        ) u_dut (
            .clk(clk), .rst(rst), .EN(en_v[gi]), .up(up_v[gi]), .down(down_v[gi]),
            .cin(cin_eff[gi]), .load(load_v[gi]), .din(din_v[gi]), .lim(lim_v[gi]),
            .out(out_w[gi]), .bcd(bcd_w[gi]), .carry(carry_w[gi]), .borrow(borrow_w[gi])
        );
    end

    always #5 clk = ~clk;

    typedef struct {
        int inst;
        int val;
        bit c;
        bit b;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_n   = 0;

    // Reference model: value per field plus "ticks held in one direction".
    int m_val   [N];
    bit m_carry [N];
    bit m_borrow[N];
    int m_held  [N];
    int m_t     [N];
    int hold_dir[N];

    function automatic int bcd_of(int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    task automatic chk(string name, int inst, int got, int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s inst%0d cycle %0d: got %0d required %0d", name, inst, cyc_n, got, want);
        end
    endtask

    task automatic model_cycle();
        int nv [N];
        bit nc [N];
        bit nb [N];
        exp_t e;
        for (int i = 0; i < N; i++) begin
            int emax, d, stp, dv;
            bit ci;
            emax = (int'(lim_v[i]) < P_MAX[i]) ? int'(lim_v[i]) : P_MAX[i];
            if (emax < P_MIN[i]) emax = P_MIN[i];
            ci = (i == 1) ? m_carry[0] : cin_v[i];
            d = 0;
            if (up_v[i] && !down_v[i]) d = 1;
            else if (down_v[i] && !up_v[i]) d = -1;
            stp   = 0;
            nv[i] = m_val[i];
            nc[i] = 1'b0;
            nb[i] = 1'b0;
            if (rst) begin
                nv[i]     = P_MIN[i];
                m_held[i] = 0;
                m_t[i]    = 0;
            end else begin
                if (en_v[i] && !load_v[i]) begin
                    if (P_MODE[i] == 0) begin
                        stp = d;
                    end else if (m_held[i] == 0) begin
                        if (d != 0) begin
                            stp       = d;
                            m_held[i] = d;
                            m_t[i]    = 1;
                        end
                    end else if (d != m_held[i]) begin
                        m_held[i] = 0;
                    end else begin
                        if (m_t[i] == P_HOLD[i] ||
                            (m_t[i] > P_HOLD[i] && ((m_t[i] - P_HOLD[i]) % P_REP[i]) == 0))
                            stp = d;
                        m_t[i]++;
                    end
                end
                if (load_v[i]) begin
                    dv    = int'(din_v[i]);
                    nv[i] = (dv < P_MIN[i]) ? P_MIN[i] : ((dv > emax) ? emax : dv);
                end else if (m_val[i] > emax) begin
                    nv[i] = emax;
                end else if (ci || stp == 1) begin
                    if (m_val[i] == emax) begin
                        nv[i] = P_MIN[i];
                        nc[i] = 1'b1;
                    end else begin
                        nv[i] = m_val[i] + 1;
                    end
                end else if (stp == -1) begin
                    if (m_val[i] == P_MIN[i]) begin
                        nv[i] = emax;
                        nb[i] = 1'b1;
                    end else begin
                        nv[i] = m_val[i] - 1;
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            m_val[i]    = nv[i];
            m_carry[i]  = nc[i];
            m_borrow[i] = nb[i];
            e.inst = i;
            e.val  = nv[i];
            e.c    = nc[i];
            e.b    = nb[i];
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every clock the DUTs present new registered outputs.
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out", e.inst, int'(out_w[e.inst]), e.val);
            chk("bcd", e.inst, int'(bcd_w[e.inst]), bcd_of(e.val));
            chk("carry", e.inst, int'(carry_w[e.inst]), int'(e.c));
            chk("borrow", e.inst, int'(borrow_w[e.inst]), int'(e.b));
        end
    end

    task automatic cyc();
        model_cycle();
        @(posedge clk);
        #2;
        cyc_n++;
    endtask

    task automatic spot(string name, int i, int v, bit c, bit b);
        chk({name, "_out"}, i, int'(out_w[i]), v);
        chk({name, "_bcd"}, i, int'(bcd_w[i]), bcd_of(v));
        chk({name, "_carry"}, i, int'(carry_w[i]), int'(c));
        chk({name, "_borrow"}, i, int'(borrow_w[i]), int'(b));
    endtask

    task automatic clear();
        en_v   = '1;
        up_v   = '0;
        down_v = '0;
        cin_v  = '0;
        load_v = '0;
        for (int i = 0; i < N; i++) begin
            din_v[i] = 8'd0;
            lim_v[i] = 8'd255;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_val[i] = 0; m_carry[i] = 1'b0; m_borrow[i] = 1'b0;
            m_held[i] = 0; m_t[i] = 0; hold_dir[i] = 0;
        end
        rst = 1'b1;
        clear();
        #1;
        cyc();
        for (int i = 0; i < N; i++) spot("reset", i, P_MIN[i], 1'b0, 1'b0);
        rst = 1'b0;

        // Up-wrap with carry.
        load_v[0] = 1'b1; din_v[0] = 8'd58; cyc(); load_v[0] = 1'b0;
        spot("t1_load", 0, 58, 1'b0, 1'b0);
        up_v[0] = 1'b1; cyc(); spot("t1_step", 0, 59, 1'b0, 1'b0);
        cyc(); spot("t1_wrap", 0, 0, 1'b1, 1'b0);
        up_v[0] = 1'b0; cyc(); spot("t1_pulse_end", 0, 0, 1'b0, 1'b0);

        // Down-wrap with borrow, then both buttons.
        down_v[0] = 1'b1; cyc(); spot("t2_borrow", 0, 59, 1'b0, 1'b1);
        up_v[0] = 1'b1; cyc(); spot("t2_both", 0, 59, 1'b0, 1'b0);
        clear(); cyc();

        // Auto-repeat: steps at ticks 0, 4, 6, 8.
        load_v[2] = 1'b1; din_v[2] = 8'd10; cyc(); load_v[2] = 1'b0;
        up_v[2] = 1'b1;
        repeat (10) cyc();
        spot("t3_repeat", 2, 14, 1'b0, 1'b0);
        up_v[2] = 1'b0; cyc();
        down_v[2] = 1'b1; cyc(); spot("t3_reverse", 2, 13, 1'b0, 1'b0);
        down_v[2] = 1'b0; cyc();

        // Run-time limit on the [1, 31] field.
        load_v[3] = 1'b1; din_v[3] = 8'd31; cyc(); load_v[3] = 1'b0;
        spot("t4_load", 3, 31, 1'b0, 1'b0);
        lim_v[3] = 8'd30; cyc(); spot("t4_clamp", 3, 30, 1'b0, 1'b0);
        up_v[3] = 1'b1; cyc(); spot("t4_wrap", 3, 1, 1'b1, 1'b0);
        up_v[3] = 1'b0; cyc();
        load_v[3] = 1'b1; din_v[3] = 8'd0; cyc(); spot("t4_load_low", 3, 1, 1'b0, 1'b0);
        clear(); cyc();

        // Cascade ripple and cin-over-button priority.
        load_v[0] = 1'b1; din_v[0] = 8'd59; load_v[1] = 1'b1; din_v[1] = 8'd12; cyc();
        clear();
        cin_v[0] = 1'b1; cyc(); spot("t5_lower", 0, 0, 1'b1, 1'b0);
        cin_v[0] = 1'b0; cyc(); spot("t5_upper", 1, 13, 1'b0, 1'b0);
        cin_v[0] = 1'b1; up_v[0] = 1'b1; cyc(); spot("t5_cin_up", 0, 1, 1'b0, 1'b0);
        clear(); cyc();

        // Reset in the middle of a repeat.
        load_v[2] = 1'b1; din_v[2] = 8'd20; cyc(); load_v[2] = 1'b0;
        up_v[2] = 1'b1;
        repeat (7) cyc();
        spot("t6_repeat", 2, 23, 1'b0, 1'b0);
        rst = 1'b1; cyc(); spot("t6_rst", 2, 0, 1'b0, 1'b0);
        rst = 1'b0; cyc(); spot("t6_first", 2, 1, 1'b0, 1'b0);
        repeat (3) cyc();
        spot("t6_hold", 2, 1, 1'b0, 1'b0);
        cyc(); spot("t6_step", 2, 2, 1'b0, 1'b0);
        clear(); cyc();

        // Randomized traffic; held directions change rarely so repeats occur.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) hold_dir[i] = int'($urandom_range(0, 3));
                up_v[i]   = (hold_dir[i] == 1) || (hold_dir[i] == 3);
                down_v[i] = (hold_dir[i] >= 2);
                en_v[i]   = ($urandom_range(0, 4) != 0);
                cin_v[i]  = ($urandom_range(0, 9) == 0);
                load_v[i] = ($urandom_range(0, 39) == 0);
                din_v[i]  = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 99) == 0)
                    lim_v[i] = ($urandom_range(0, 1) == 0) ? 8'd255 : 8'($urandom_range(0, 70));
            end
            cyc();
        end
        rst = 1'b0;
        clear();
        repeat (2) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
